// File: rtl/delay_ctrl.sv
// delay_ctrl: sequencer for a sample delay line.
// A programmable divider produces a one-cycle sample strobe; the block
// first fills the line with `target` samples, then runs, ramping the
// applied offset one step per strobe toward the configured target while
// never pointing past data that has actually been written.
module delay_ctrl #(
   parameter int ADDRESS_WIDTH = 9,
   parameter int DIV_WIDTH     = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     stop,
   input  logic                     cfg_valid,
   output logic                     cfg_ready,
   input  logic [ADDRESS_WIDTH-1:0] cfg_offset,
   input  logic [DIV_WIDTH-1:0]     cfg_div,
   output logic                     sample_en,
   output logic [ADDRESS_WIDTH-1:0] offset,
   output logic                     out_valid,
   output logic                     busy
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_FILL = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

   // written count saturates here so it never wraps back below live data
   localparam logic [ADDRESS_WIDTH-1:0] WR_MAX = '1;

   logic [1:0]               state;
   logic [1:0]               state_nxt;
   logic [DIV_WIDTH-1:0]     div_cnt;
   logic [DIV_WIDTH-1:0]     div_q;
   logic [ADDRESS_WIDTH-1:0] written;
   logic [ADDRESS_WIDTH-1:0] target;
   logic [ADDRESS_WIDTH:0]   off_inc;
   logic                     tick;
   logic                     cfg_xfer;
   logic                     fill_done;
   logic                     step_up;
   logic                     step_dn;

   assign busy      = (state != ST_IDLE);
   assign tick      = busy && (div_cnt == div_q);
   assign sample_en = tick;
   assign cfg_xfer  = cfg_valid && cfg_ready;
   assign fill_done = (written >= target);
   assign out_valid = (state == ST_RUN) && (written >= offset);

   // one extra bit so offset+1 cannot overflow at the top of the range
   assign off_inc = {1'b0, offset} + (ADDRESS_WIDTH+1)'(1);
   assign step_up = (offset < target) && (off_inc <= {1'b0, written});
   assign step_dn = (offset > target);

   // config is accepted while idle, never while filling, and while
   // running only once the previous ramp has settled on its target
   always_comb begin
      cfg_ready = 1'b0;
      case (state)
         ST_IDLE: cfg_ready = 1'b1;
         ST_FILL: cfg_ready = 1'b0;
         ST_RUN:  cfg_ready = (offset == target);
         default: cfg_ready = 1'b0;
      endcase
   end

   // next-state decode; stop always wins over start and fill completion
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (start && !stop) state_nxt = ST_FILL;
         ST_FILL: begin
            if (stop)           state_nxt = ST_IDLE;
            else if (fill_done) state_nxt = ST_RUN;
         end
         ST_RUN:  if (stop) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nxt;
   end

   // sample-rate divider: held at zero while idle so a start always
   // begins a fresh period, counts 0..div while busy
   always_ff @(posedge clk) begin
      if (rst || state == ST_IDLE) div_cnt <= '0;
      else if (tick)               div_cnt <= '0;
      else                         div_cnt <= div_cnt + DIV_WIDTH'(1);
   end

   // samples written since start, saturating at the buffer depth
   always_ff @(posedge clk) begin
      if (rst || state == ST_IDLE)       written <= '0;
      else if (tick && written != WR_MAX) written <= written + ADDRESS_WIDTH'(1);
   end

   // divider and target: full load while idle, target-only while running
   always_ff @(posedge clk) begin
      if (rst) begin
         div_q  <= '0;
         target <= '0;
      end else if (cfg_xfer) begin
         target <= cfg_offset;
         if (state == ST_IDLE) div_q <= cfg_div;
      end
   end

   // applied offset: direct load while idle, otherwise one step per strobe
   always_ff @(posedge clk) begin
      if (rst) begin
         offset <= '0;
      end else if (cfg_xfer && state == ST_IDLE) begin
         offset <= cfg_offset;
      end else if (state == ST_RUN && tick && !cfg_xfer) begin
         if (step_up)      offset <= off_inc[ADDRESS_WIDTH-1:0];
         else if (step_dn) offset <= offset - ADDRESS_WIDTH'(1);
      end
   end

endmodule

// File: tb/tb_delay_ctrl.sv
// Bench for delay_ctrl: stimulus pushes expected strobes and output
// snapshots into queues; a negedge monitor pops and compares them.
module tb_delay_ctrl;
   localparam int AW = 9;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic          cfg_valid = 1'b0;
   logic [AW-1:0] cfg_offset = '0;
   logic [DW-1:0] cfg_div = '0;
   logic          cfg_ready;
   logic          sample_en;
   logic [AW-1:0] offset;
   logic          out_valid;
   logic          busy;

   delay_ctrl #(.ADDRESS_WIDTH(AW), .DIV_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .start(start), .stop(stop),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_offset(cfg_offset), .cfg_div(cfg_div),
      .sample_en(sample_en), .offset(offset),
      .out_valid(out_valid), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      string tag;
      int    cyc;
      int    off;
      logic  ov;
   } strobe_t;

   typedef struct {
      string tag;
      int    cyc;
      logic  bsy;
      logic  rdy;
      logic  se;
      logic  ov;
      int    off;
   } probe_t;

   strobe_t sb[$];
   probe_t  pq[$];
   int      n_cmp = 0;
   int      n_bad = 0;
   logic    done = 1'b0;
   logic    final_done = 1'b0;

   task automatic push(string tag, int c, int off, logic ov);
      strobe_t e;
      e.tag = tag; e.cyc = c; e.off = off; e.ov = ov;
      sb.push_back(e);
   endtask

   task automatic probe(string tag, logic bsy, logic rdy, logic se, logic ov, int off);
      probe_t p;
      p.tag = tag; p.cyc = cyc; p.bsy = bsy; p.rdy = rdy; p.se = se; p.ov = ov; p.off = off;
      pq.push_back(p);
   endtask

   task automatic wait_cyc(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cfg(int o, int d);
      cfg_valid = 1'b1; cfg_offset = AW'(o); cfg_div = DW'(d);
      wait_cyc(1);
      cfg_valid = 1'b0;
   endtask

   task automatic go(output int s);
      start = 1'b1;
      wait_cyc(1);
      start = 1'b0;
      s = cyc;
   endtask

   // monitor: compares every strobe and every scheduled snapshot
   always @(negedge clk) begin : monitor
      strobe_t e;
      probe_t  p;
      while (sb.size() != 0 && sb[0].cyc < cyc) begin
         e = sb.pop_front();
         n_cmp++; n_bad++;
         $display("FAIL %s missing strobe: none at cycle %0d, required off=%0d ov=%0b", e.tag, e.cyc, e.off, e.ov);
      end
      if (sample_en === 1'b1) begin
         n_cmp++;
         if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected strobe at cycle %0d (offset=%0d out_valid=%0b)", cyc, offset, out_valid);
         end else begin
            e = sb.pop_front();
            if (e.cyc != cyc || int'(offset) != e.off || out_valid !== e.ov) begin
               n_bad++;
               $display("FAIL %s strobe: got cyc=%0d off=%0d ov=%0b, required cyc=%0d off=%0d ov=%0b",
                        e.tag, cyc, offset, out_valid, e.cyc, e.off, e.ov);
            end
         end
      end
      while (pq.size() != 0 && pq[0].cyc <= cyc) begin
         p = pq.pop_front();
         n_cmp++;
         if (p.cyc != cyc || busy !== p.bsy || cfg_ready !== p.rdy || sample_en !== p.se ||
             out_valid !== p.ov || int'(offset) != p.off) begin
            n_bad++;
            $display("FAIL %s snapshot @%0d: got busy=%0b rdy=%0b se=%0b ov=%0b off=%0d, required busy=%0b rdy=%0b se=%0b ov=%0b off=%0d",
                     p.tag, cyc, busy, cfg_ready, sample_en, out_valid, offset,
                     p.bsy, p.rdy, p.se, p.ov, p.off);
         end
      end
      if (done && !final_done) begin
         final_done = 1'b1;
         n_cmp++;
         if (sb.size() != 0 || pq.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d strobes / %0d snapshots pending, required 0", sb.size(), pq.size());
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int s;
      int o;
      // reset values
      wait_cyc(2);
      probe("reset", 1'b0, 1'b1, 1'b0, 1'b0, 0);
      rst = 1'b0;
      wait_cyc(1);

      // offset 4, div 2: strobe every 3rd cycle, RUN after the 4th strobe
      cfg(4, 2);
      go(s);
      for (int k = 1; k <= 5; k++) push("A", s + 2 + 3*(k-1), 4, k == 5);
      probe("A_fill", 1'b1, 1'b0, 1'b0, 1'b0, 4);
      wait_cyc(15);
      probe("A_run", 1'b1, 1'b1, 1'b0, 1'b1, 4);
      stop = 1'b1; wait_cyc(1); stop = 1'b0;
      probe("A_stop", 1'b0, 1'b1, 1'b0, 1'b0, 4);

      // div 0, offset 0: RUN the cycle after FILL entry, continuous strobes
      cfg(0, 0);
      go(s);
      push("B", s, 0, 1'b0);
      for (int k = 2; k <= 6; k++) push("B", s + k - 1, 0, 1'b1);
      wait_cyc(1);
      probe("B_run", 1'b1, 1'b1, 1'b1, 1'b1, 0);
      wait_cyc(4);
      stop = 1'b1; wait_cyc(1); stop = 1'b0;
      probe("B_stop", 1'b0, 1'b1, 1'b0, 1'b0, 0);

      // running at offset 4 with 10 written, retarget to 7 (cfg_div ignored)
      cfg(4, 1);
      go(s);
      for (int k = 1; k <= 14; k++) begin
         o = (k <= 11) ? 4 : (k == 12) ? 5 : (k == 13) ? 6 : 7;
         push("C", s + 1 + 2*(k-1), o, k >= 5);
      end
      wait_cyc(20);
      cfg_valid = 1'b1; cfg_offset = AW'(7); cfg_div = DW'(9);
      wait_cyc(1);
      cfg_valid = 1'b0;
      probe("C_ramp", 1'b1, 1'b0, 1'b1, 1'b1, 4);
      wait_cyc(5);
      probe("C_done", 1'b1, 1'b1, 1'b0, 1'b1, 7);
      wait_cyc(1);
      stop = 1'b1; wait_cyc(1); stop = 1'b0;
      probe("C_stop", 1'b0, 1'b1, 1'b0, 1'b0, 7);

      // transfer+stop together, then restart with offset ahead of written data
      cfg(8, 0);
      go(s);
      for (int k = 1; k <= 10; k++) push("D1", s + k - 1, 8, k == 10);
      wait_cyc(9);
      cfg_valid = 1'b1; cfg_offset = AW'(2); stop = 1'b1;
      wait_cyc(1);
      cfg_valid = 1'b0; stop = 1'b0;
      probe("D_xfer_stop", 1'b0, 1'b1, 1'b0, 1'b0, 8);
      go(s);
      push("D2", s,     8, 1'b0);
      push("D2", s + 1, 8, 1'b0);
      push("D2", s + 2, 8, 1'b0);
      push("D2", s + 3, 8, 1'b0);
      push("D2", s + 4, 7, 1'b0);
      push("D2", s + 5, 6, 1'b0);
      push("D2", s + 6, 5, 1'b1);
      push("D2", s + 7, 4, 1'b1);
      push("D2", s + 8, 3, 1'b1);
      push("D2", s + 9, 2, 1'b1);
      wait_cyc(3);
      probe("D_down", 1'b1, 1'b0, 1'b1, 1'b0, 8);
      wait_cyc(6);
      probe("D_settled", 1'b1, 1'b1, 1'b1, 1'b1, 2);
      stop = 1'b1; wait_cyc(1); stop = 1'b0;
      probe("D_stop", 1'b0, 1'b1, 1'b0, 1'b0, 2);

      // start and stop together while idle: stays idle
      start = 1'b1; stop = 1'b1;
      wait_cyc(1);
      start = 1'b0; stop = 1'b0;
      probe("startstop", 1'b0, 1'b1, 1'b0, 1'b0, 2);
      wait_cyc(3);
      probe("startstop2", 1'b0, 1'b1, 1'b0, 1'b0, 2);

      // 600 strobes: written saturates at 511, offset ramps all the way up
      cfg(0, 0);
      go(s);
      for (int k = 1; k <= 600; k++) begin
         o = (k <= 2) ? 0 : ((k - 3 > 511) ? 511 : k - 3);
         push("E", s + k - 1, o, k >= 2);
      end
      wait_cyc(1);
      cfg_valid = 1'b1; cfg_offset = AW'(511);
      wait_cyc(1);
      cfg_valid = 1'b0;
      probe("E_ramp", 1'b1, 1'b0, 1'b1, 1'b1, 0);
      wait_cyc(597);
      probe("E_sat", 1'b1, 1'b1, 1'b1, 1'b1, 511);
      stop = 1'b1; wait_cyc(1); stop = 1'b0;

      // reset mid-RUN, overriding start and a config offer in the same cycle
      cfg(0, 3);
      go(s);
      push("F", s + 3, 0, 1'b1);
      push("F", s + 7, 0, 1'b1);
      wait_cyc(8);
      rst = 1'b1; start = 1'b1; cfg_valid = 1'b1; cfg_offset = AW'(5); cfg_div = DW'(7);
      wait_cyc(1);
      rst = 1'b0; start = 1'b0; cfg_valid = 1'b0;
      probe("F_rst", 1'b0, 1'b1, 1'b0, 1'b0, 0);
      wait_cyc(4);
      probe("F_quiet", 1'b0, 1'b1, 1'b0, 1'b0, 0);

      // after reset div=0 and target=0: immediate RUN, strobe every cycle
      go(s);
      push("G", s,     0, 1'b0);
      push("G", s + 1, 0, 1'b1);
      push("G", s + 2, 0, 1'b1);
      wait_cyc(2);
      stop = 1'b1; wait_cyc(1); stop = 1'b0;
      probe("G_stop", 1'b0, 1'b1, 1'b0, 1'b0, 0);

      wait_cyc(2);
      done = 1'b1;
      wait_cyc(3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
